// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
package rf_pkg;

  localparam int RF_XLEN_DEF = 64;
  localparam int RF_NREG_DEF = 32;

  function automatic int rf_aw(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 zeroing, write-to-read bypass with the
// highest-indexed write port winning, and busy masking while a write lands.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEF,
  parameter int AW   = 5,
  parameter int NWR  = 1
) (
  input  logic                rst_n,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rf_data,
  input  logic                rf_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  output logic [XLEN-1:0]     rd_data,
  output logic                rd_busy
);

  logic            hit;
  logic [XLEN-1:0] data;

  always_comb begin
    hit  = 1'b0;
    data = rf_data;
    // Ascending scan so the last match (highest port) is what gets forwarded.
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
        hit  = 1'b1;
        data = wr_data[w*XLEN +: XLEN];
      end
    end
    rd_data = data;
    rd_busy = rf_busy && !hit;
    if (!rst_n || (rd_addr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired-zero x0, same-cycle
// write bypass and a per-register pending-writeback scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEF,
  parameter int NREG = RF_NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  parameter int AW   = rf_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                wr_conflict
);

  // No handshakes: a write with wr_en set, or an issue with iss_en set, is
  // taken unconditionally at the next posedge while rst_n is high.

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            conflict;

  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
        rf_d[wr_addr[w*AW +: AW]]   = wr_data[w*XLEN +: XLEN];
        busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the clears: a new producer replaces the one writing back.
    if (iss_en && (iss_addr != '0)) begin
      busy_d[iss_addr] = 1'b1;
    end
    rf_d[0]   = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int a = 0; a < NWR; a++) begin
      for (int b = a + 1; b < NWR; b++) begin
        if (wr_en[a] && wr_en[b] && (wr_addr[a*AW +: AW] == wr_addr[b*AW +: AW]) &&
            (wr_addr[a*AW +: AW] != '0)) begin
          conflict = 1'b1;
        end
      end
    end
    wr_conflict = conflict && rst_n;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];

    rf_read_port #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_port (
      .rst_n   (rst_n),
      .rd_addr (addr),
      .rf_data (rf_q[addr]),
      .rf_busy (busy_q[addr]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data[p*XLEN +: XLEN]),
      .rd_busy (rd_busy[p])
    );
  end

endmodule
